// File: rtl/fpalu_pkg.sv
// ---- fpalu_pkg : shared floating-point ALU sizes and sqrt sequencer state type (rev 1.0) ----
`default_nettype none

package fpalu_pkg;

  localparam int DEFAULT_MANTISSA_SIZE = 52;
  localparam int DEFAULT_BINARY_SIZE   = 2 * (DEFAULT_MANTISSA_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage

`default_nettype wire

// File: rtl/sqrt_digit_step.sv
// ---- sqrt_digit_step : one restoring radix-2 square-root iteration, purely combinational (rev 1.0) ----
`default_nettype none

module sqrt_digit_step
  import fpalu_pkg::*;
#(
  parameter int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE
) (
  input  logic [MANTISSA_SIZE+2:0] rem_in,
  input  logic [MANTISSA_SIZE:0]   root_in,
  input  logic [1:0]               pair,
  output logic [MANTISSA_SIZE+2:0] rem_out,
  output logic [MANTISSA_SIZE:0]   root_out
);

  logic [MANTISSA_SIZE+2:0] shifted;
  logic [MANTISSA_SIZE+2:0] trial;
  logic                     fits;
  logic                     unused_rem_msbs;

  // A remainder entering a step never exceeds 2*root, so its top two bits are
  // always zero and can be dropped by the shift.
  assign shifted  = {rem_in[MANTISSA_SIZE:0], pair};
  assign trial    = {root_in, 2'b01};
  assign fits     = (shifted >= trial);
  assign rem_out  = fits ? (shifted - trial) : shifted;
  assign root_out = {root_in[MANTISSA_SIZE-1:0], fits};

  assign unused_rem_msbs = ^rem_in[MANTISSA_SIZE+2:MANTISSA_SIZE+1];

endmodule

`default_nettype wire

// File: rtl/fp_sqrt_digit_recurrence.sv
// ---- fp_sqrt_digit_recurrence : truncated floor(sqrt(radicand)), one root bit per clock (rev 1.0) ----
`default_nettype none

module fp_sqrt_digit_recurrence
  import fpalu_pkg::*;
#(
  parameter int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE,
  parameter int BINARY_SIZE   = DEFAULT_BINARY_SIZE
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [BINARY_SIZE-1:0]   radicand,
  output logic                     busy,
  output logic                     done,
  output logic                     root_hidden,
  output logic [MANTISSA_SIZE-1:0] mantissa,
  output logic                     inexact
);

  localparam int CNT_W = $clog2(MANTISSA_SIZE + 1);

  sqrt_state_t              state;
  sqrt_state_t              next_state;
  logic [CNT_W-1:0]         count;
  logic [MANTISSA_SIZE+2:0] rem;
  logic [MANTISSA_SIZE+2:0] rem_next;
  logic [MANTISSA_SIZE:0]   root;
  logic [MANTISSA_SIZE:0]   root_next;
  logic [BINARY_SIZE-1:0]   shreg;

  sqrt_digit_step #(
    .MANTISSA_SIZE(MANTISSA_SIZE)
  ) u_step (
    .rem_in  (rem),
    .root_in (root),
    .pair    (shreg[BINARY_SIZE-1 -: 2]),
    .rem_out (rem_next),
    .root_out(root_next)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = ITER;
      end
      ITER: if (count == '0) next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers load only on the final iteration, so they hold from done
  // until the following operation completes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count       <= '0;
      rem         <= '0;
      root        <= '0;
      shreg       <= '0;
      root_hidden <= 1'b0;
      mantissa    <= '0;
      inexact     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shreg <= radicand;
          rem   <= '0;
          root  <= '0;
          count <= CNT_W'(MANTISSA_SIZE);
        end
        ITER: begin
          rem   <= rem_next;
          root  <= root_next;
          shreg <= {shreg[BINARY_SIZE-3:0], 2'b00};
          if (count == '0) begin
            root_hidden <= root_next[MANTISSA_SIZE];
            mantissa    <= root_next[MANTISSA_SIZE-1:0];
            inexact     <= |rem_next;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fp_sqrt_digit_recurrence.md
FP_SQRT_DIGIT_RECURRENCE -- requirements
Module: fp_sqrt_digit_recurrence

Interface
REQ-001 SHALL have parameter MANTISSA_SIZE, default 52, stored fraction width of the result.
REQ-002 SHALL have parameter BINARY_SIZE, default 106, radicand width (2*(MANTISSA_SIZE+1)).
REQ-003 SHALL have port Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port radicand  input  BINARY_SIZE  unsigned integer; sampled in the start-acceptance cycle.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port root_hidden  output  1  root bit MANTISSA_SIZE (hidden bit).
REQ-010 SHALL have port mantissa  output  MANTISSA_SIZE  root bits MANTISSA_SIZE-1:0.
REQ-011 SHALL have port inexact  output  1  final remainder non-zero.

Function
REQ-012 SHALL compute root = floor(sqrt(radicand)), MANTISSA_SIZE+1 bits, truncated; no rounding inside this block.
REQ-013 SHALL use restoring radix-2 recurrence: rem = (rem<<2) | next two radicand bits (MSB pair first); trial = (root<<2)|1; if rem >= trial then rem -= trial, root = (root<<1)|1, else root = root<<1.
REQ-014 SHALL size rem to MANTISSA_SIZE+3 bits and root to MANTISSA_SIZE+1 bits; no intermediate overflow.
REQ-015 SHALL implement states IDLE, ITER, DONE.
REQ-016 IDLE: start=1 captures radicand, clears rem/root, loads iteration counter with MANTISSA_SIZE, goes to ITER; start=0 stays.
REQ-017 ITER: one root bit per cycle; when counter = 0 the final bit is produced and state goes to DONE; otherwise counter decrements.
REQ-018 DONE: done=1 for exactly one cycle, outputs valid; next state IDLE unconditionally.
REQ-019 SHALL take MANTISSA_SIZE+1 (53) ITER cycles; done rises on the 54th rising edge after the start-acceptance edge.
REQ-020 SHALL ignore start while in ITER or DONE; no queuing, and the captured radicand does not change.
REQ-021 SHALL hold root_hidden, mantissa and inexact stable from done until the next start acceptance, then they may change.
REQ-022 radicand = 0 SHALL give root_hidden=0, mantissa=0, inexact=0 with normal latency; no special-case shortcut.
REQ-023 start asserted in the cycle following done SHALL be accepted as a normal IDLE start.

Reset
REQ-024 Reset SHALL force state IDLE, busy=0, done=0, root_hidden=0, mantissa=0, inexact=0, counter=0, rem=0 immediately, independent of Clock.
REQ-025 Reset mid-ITER SHALL abandon the operation with no done pulse; the first start after reset release is processed normally.

Structure
REQ-026 Shared package fpalu_pkg SHALL hold MANTISSA_SIZE/BINARY_SIZE defaults and the sqrt state enum typedef.
REQ-027 One combinational sub-module sqrt_digit_step SHALL perform a single REQ-013 iteration (rem, root, radicand pair in; new rem, root out).
REQ-028 Top level SHALL contain only the FSM, counter, radicand shift register and output registers.

Verification
REQ-029 radicand = 2^104 -> done at edge 54, root_hidden=1, mantissa=0, inexact=0.
REQ-030 radicand = 2^105 -> root_hidden=1, mantissa=52'h6A09E667F3BCC, inexact=1.
REQ-031 radicand = 9*2^102 (2.25*2^104) -> root_hidden=1, mantissa=52'h8000000000000, inexact=0.
REQ-032 radicand = 0 -> done at edge 54, all result outputs 0, busy high for 54 cycles.
REQ-033 Second start with a different radicand during ITER -> ignored; result matches the first radicand; single done pulse.
REQ-034 Reset asserted at ITER cycle 20 -> outputs zero immediately, no done; then start with radicand 2^104 -> correct result at edge 54.
